// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the two requester ports, the response port and the memory port of dmem_arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req and command until their grant pulse; no other flow control.
interface dmem_arbiter_if;
  // requester 0 (CPU) and requester 1 (loader/debug) command channels
  logic        m0_req;
  logic        m0_we;
  logic [15:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_gnt;
  logic        m1_req;
  logic        m1_we;
  logic [15:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_gnt;

  // shared response channel
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  // single-port memory with combinational read data
  logic        mem_cs;
  logic        mem_rw_;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output mem_cs, mem_rw_, mem_addr, mem_wdata
  );

  // requesters plus memory model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  mem_cs, mem_rw_, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter giving two requesters access to one data memory, with range check.
// Latency: grant one cycle after req seen, response the cycle after grant; one access per 2 cycles max.
// Backpressure: a requester waits, holding req/command, until its one-cycle grant pulse.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 511
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;          // id of the requester granted last
  logic        cmd_id_q, cmd_id_d;
  logic        cmd_we_q, cmd_we_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_wdata_q, cmd_wdata_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  logic        any_req;
  logic        win_id;
  logic        win_we;
  logic [15:0] win_addr;
  logic [15:0] win_wdata;
  logic        in_range;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_req   = bus.m0_req | bus.m1_req;
    win_id    = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      win_id = ~ptr_q;
    end else begin
      win_id = bus.m1_req;
    end
    win_we    = win_id ? bus.m1_we    : bus.m0_we;
    win_addr  = win_id ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win_id ? bus.m1_wdata : bus.m0_wdata;
    // Full 16-bit unsigned compare, widened so a limit above 0xFFFF admits everything.
    in_range  = ({16'd0, cmd_addr_q} < ADDR_LIMIT);
  end

  // Next-state logic: arbitrate from IDLE or RESP, capture read data at the end of ACCESS.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d     = ACCESS;
          ptr_d       = win_id;
          cmd_id_d    = win_id;
          cmd_we_d    = win_we;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d  = RESP;
        rsp_id_d = cmd_id_q;
        // Writes and rejected accesses report zero data.
        if (!cmd_we_q && in_range) begin
          rsp_rdata_d = bus.mem_rdata;
        end else begin
          rsp_rdata_d = 16'h0000;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: grant and memory strobes in ACCESS, response strobes in RESP.
  always_comb begin
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.mem_cs    = 1'b0;
    bus.mem_rw_   = 1'b1;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      ACCESS: begin
        bus.m0_gnt = ~cmd_id_q;
        bus.m1_gnt = cmd_id_q;
        if (in_range) begin
          // Gating with rst_n keeps a write from landing on the edge that resets us.
          bus.mem_cs    = rst_n;
          bus.mem_rw_   = ~cmd_we_q;
          bus.mem_addr  = cmd_addr_q;
          bus.mem_wdata = cmd_wdata_q;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = ~in_range;
      end
      default: begin
      end
    endcase
    bus.rsp_id    = rsp_id_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

  // State registers with synchronous active-low reset; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 16'h0000;
      cmd_wdata_q <= 16'h0000;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 511: first out-of-range word address; addresses >= ADDR_LIMIT are rejected.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 m0_req, m1_req  in  1 each  access request from requester 0 (CPU load/store) / requester 1 (loader/debug).
REQ-005 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  in  16 each  word address.
REQ-007 m0_wdata, m1_wdata  in  16 each  write data.
REQ-008 m0_gnt, m1_gnt  out  1 each  one-cycle grant pulse; command accepted.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_id  out  1  requester owning the response.
REQ-011 rsp_rdata  out  16  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  1 = address out of range, access suppressed.
REQ-013 mem_cs  out  1  memory chip select.
REQ-014 mem_rw_  out  1  1 = read, 0 = write.
REQ-015 mem_addr, mem_wdata  out  16 each  memory address / write data.
REQ-016 mem_rdata  in  16  combinational memory read data.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-018 IDLE: any req high -> arbitrate, latch winner's we/addr/wdata/id, go to ACCESS next cycle; no req -> stay IDLE.
REQ-019 Arbitration round-robin: single requester wins outright; both high -> winner is requester not granted last; last-grant pointer resets to 1 (m0 wins first tie).
REQ-020 ACCESS lasts exactly one cycle; winner's gnt high only in this cycle, other gnt low.
REQ-021 ACCESS, in range: mem_cs = 1, mem_rw_ = ~we, mem_addr/mem_wdata = latched values; write commits at end-of-ACCESS edge.
REQ-022 ACCESS, read: mem_rdata sampled into rsp_rdata register at end-of-ACCESS edge.
REQ-023 ACCESS, addr >= ADDR_LIMIT: mem_cs = 0, no memory access, rsp_err = 1, rsp_rdata = 0 in following RESP.
REQ-024 mem_cs SHALL be combinationally gated by rst_n, so no write commits on an edge where rst_n = 0.
REQ-025 RESP lasts exactly one cycle: rsp_valid = 1, rsp_id = latched id; rsp_rdata = 0 for writes.
REQ-026 RESP -> ACCESS directly if any req high (arbitrated as in IDLE, pointer updated), else -> IDLE; max throughput one access per 2 cycles.
REQ-027 Requester holds req and command stable until its gnt; a req still high in the cycle after gnt is a new request.
REQ-028 Outside ACCESS: mem_cs = 0, mem_rw_ = 1, mem_addr = 0, mem_wdata = 0.
REQ-029 Outside RESP: rsp_valid = 0, rsp_err = 0; rsp_id/rsp_rdata hold last values.
REQ-030 Address compare unsigned over full 16 bits; no wrap or truncation.

Reset
REQ-031 rst_n = 0 at a rising edge: state = IDLE, pointer = 1, all gnt = 0, rsp_valid = 0, rsp_err = 0, rsp_id = 0, rsp_rdata = 0, latched command cleared.
REQ-032 Reset in ACCESS or RESP aborts the transaction: no write commits, no response issued after reset release.

Verification
REQ-033 m0 write addr 0x0010 data 0xBEEF -> m0_gnt pulse cycle N+1 with mem_cs=1, mem_rw_=0; rsp_valid cycle N+2, rsp_id=0, rsp_err=0; memory[0x10]=0xBEEF.
REQ-034 m1 read addr 0x0010 after REQ-033 -> rsp_valid, rsp_id=1, rsp_rdata=0xBEEF, rsp_err=0.
REQ-035 m0 and m1 both hold req from reset -> grants alternate m0, m1, m0, m1 at 2-cycle spacing; gnt never both high.
REQ-036 m0 read addr 0x01FF (511) and 0xFFFF -> mem_cs stays 0; rsp_err=1, rsp_rdata=0x0000; addr 0x01FE succeeds.
REQ-037 m1 write 0x1234 to 0x0020, rst_n low during ACCESS cycle -> memory[0x20] unchanged, no rsp_valid, state IDLE after release.
REQ-038 m0 read response followed same cycle by pending m1 req in RESP -> m1 ACCESS next cycle, no intervening IDLE.
